mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 22 ++
 rtl/mem_arbiter_if.sv | 70 +++++++
 rtl/mem_arbiter_pick.sv | 25 ++
 rtl/mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_arbiter.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared definitions for the memory arbiter slice.
//   - default widths for line address, beat data and memory tag
//   - fixed memory tags that identify the owning cache
//   - FSM state encoding used by mem_arbiter
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 28;
  localparam int DATA_W_DEF = 128;
  localparam int TAG_W_DEF  = 4;

  // Memory tags identify which cache owns the single outstanding transaction.
  localparam int TAG_ICACHE = 0;
  localparam int TAG_DCACHE = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    WDATA = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles every handshake/bus signal around the arbiter.
//   icache : ic_req_valid/ready/addr, ic_resp_valid/data
//   dcache : dc_req_valid/ready/rnw/addr/data/mask, dc_resp_valid/data
//   memory : mem_req_valid/ready/rnw/addr/tag,
//            mem_req_data_valid/ready/bits/mask,
//            mem_resp_valid/data/tag
// Modports: slave  = the arbiter's view,
//           master = the surrounding caches + memory.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int TAG_W  = TAG_W_DEF
);
  localparam int MASK_W = DATA_W / 8;

  logic              ic_req_valid;
  logic              ic_req_ready;
  logic [ADDR_W-1:0] ic_req_addr;
  logic              ic_resp_valid;
  logic [DATA_W-1:0] ic_resp_data;

  logic              dc_req_valid;
  logic              dc_req_ready;
  logic              dc_req_rnw;
  logic [ADDR_W-1:0] dc_req_addr;
  logic [DATA_W-1:0] dc_req_data;
  logic [MASK_W-1:0] dc_req_mask;
  logic              dc_resp_valid;
  logic [DATA_W-1:0] dc_resp_data;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_rnw;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [TAG_W-1:0]  mem_req_tag;
  logic              mem_req_data_valid;
  logic              mem_req_data_ready;
  logic [DATA_W-1:0] mem_req_data_bits;
  logic [MASK_W-1:0] mem_req_data_mask;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_data;
  logic [TAG_W-1:0]  mem_resp_tag;

  modport slave (
    input  ic_req_valid, ic_req_addr,
    output ic_req_ready, ic_resp_valid, ic_resp_data,
    input  dc_req_valid, dc_req_rnw, dc_req_addr, dc_req_data, dc_req_mask,
    output dc_req_ready, dc_resp_valid, dc_resp_data,
    output mem_req_valid, mem_req_rnw, mem_req_addr, mem_req_tag,
    input  mem_req_ready,
    output mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
    input  mem_req_data_ready,
    input  mem_resp_valid, mem_resp_data, mem_resp_tag
  );

  modport master (
    output ic_req_valid, ic_req_addr,
    input  ic_req_ready, ic_resp_valid, ic_resp_data,
    output dc_req_valid, dc_req_rnw, dc_req_addr, dc_req_data, dc_req_mask,
    input  dc_req_ready, dc_resp_valid, dc_resp_data,
    input  mem_req_valid, mem_req_rnw, mem_req_addr, mem_req_tag,
    output mem_req_ready,
    input  mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
    output mem_req_data_ready,
    output mem_resp_valid, mem_resp_data, mem_resp_tag
  );

endinterface

// File: rtl/mem_arbiter_pick.sv
// mem_arbiter_pick: combinational grant selector.
//   ic_valid, dc_valid : pending requests
//   dc_first           : 1 = dcache wins a tie, 0 = icache wins a tie
//   grant_ic, grant_dc : one-hot (or zero) grant
module mem_arbiter_pick (
  input  logic ic_valid,
  input  logic dc_valid,
  input  logic dc_first,
  output logic grant_ic,
  output logic grant_dc
);

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_ic = 1'b0;
    grant_dc = 1'b0;
    if (dc_valid && (dc_first || !ic_valid)) begin
      grant_dc = 1'b1;
    end else if (ic_valid) begin
      grant_ic = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an icache (reads only) and a
// dcache (reads and masked writes), one transaction outstanding at a time.
//   clk   : single clock, rising edge
//   reset : synchronous, active-high
//   bus   : mem_arbiter_if.slave (cache request/response + memory channels)
// Build option: define MEM_ARBITER_RR_EN for round-robin tie-breaking;
// otherwise the dcache always wins a tie.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int TAG_W  = TAG_W_DEF
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  localparam int MASK_W = DATA_W / 8;
  localparam logic [TAG_W-1:0] TAG_IC = TAG_W'(TAG_ICACHE);
  localparam logic [TAG_W-1:0] TAG_DC = TAG_W'(TAG_DCACHE);

  arb_state_e state, state_nxt;

  logic              grant_ic, grant_dc, dc_first;
  logic              accept, done, resp_hit;
  logic              owner_dc, rnw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [MASK_W-1:0] mask_q;
  logic [TAG_W-1:0]  tag_q;
  logic              ic_resp_valid_q, dc_resp_valid_q;
  logic [DATA_W-1:0] resp_data_q;

  mem_arbiter_pick u_pick (
    .ic_valid (bus.ic_req_valid),
    .dc_valid (bus.dc_req_valid),
    .dc_first (dc_first),
    .grant_ic (grant_ic),
    .grant_dc (grant_dc)
  );

`ifdef MEM_ARBITER_RR_EN
  // Pointer flips to the other requester whenever a transaction completes.
  logic rr_dc_next;
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_dc_next <= 1'b1;
    end else if (done) begin
      rr_dc_next <= !owner_dc;
    end
  end
  assign dc_first = rr_dc_next;
`else
  assign dc_first = 1'b1;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and handshake outputs. All valid/ready outputs are forced low
  // while reset is high, even before the first reset edge has landed.
  always_comb begin
    state_nxt              = state;
    accept                 = 1'b0;
    done                   = 1'b0;
    resp_hit               = 1'b0;
    bus.ic_req_ready       = 1'b0;
    bus.dc_req_ready       = 1'b0;
    bus.mem_req_valid      = 1'b0;
    bus.mem_req_data_valid = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          bus.ic_req_ready = grant_ic;
          bus.dc_req_ready = grant_dc;
          if (grant_ic || grant_dc) begin
            accept    = 1'b1;
            state_nxt = CMD;
          end
        end
        CMD: begin
          bus.mem_req_valid = 1'b1;
          if (bus.mem_req_ready) state_nxt = rnw_q ? RESP : WDATA;
        end
        WDATA: begin
          bus.mem_req_data_valid = 1'b1;
          if (bus.mem_req_data_ready) begin
            done      = 1'b1;
            state_nxt = IDLE;
          end
        end
        RESP: begin
          // Responses carrying any other tag are not ours and are dropped.
          if (bus.mem_resp_valid && bus.mem_resp_tag == tag_q) begin
            resp_hit  = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Request capture and registered response. The wide address/data registers
  // are cleared on reset because the block's idle state defines them as zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_dc        <= 1'b0;
      rnw_q           <= 1'b0;
      addr_q          <= '0;
      data_q          <= '0;
      mask_q          <= '0;
      tag_q           <= '0;
      ic_resp_valid_q <= 1'b0;
      dc_resp_valid_q <= 1'b0;
      resp_data_q     <= '0;
    end else begin
      ic_resp_valid_q <= 1'b0;
      dc_resp_valid_q <= 1'b0;
      if (accept) begin
        owner_dc <= grant_dc;
        rnw_q    <= grant_dc ? bus.dc_req_rnw : 1'b1;
        addr_q   <= grant_dc ? bus.dc_req_addr : bus.ic_req_addr;
        data_q   <= grant_dc ? bus.dc_req_data : '0;
        mask_q   <= grant_dc ? bus.dc_req_mask : '0;
        tag_q    <= grant_dc ? TAG_DC : TAG_IC;
      end
      if (resp_hit) begin
        ic_resp_valid_q <= !owner_dc;
        dc_resp_valid_q <= owner_dc;
        resp_data_q     <= bus.mem_resp_data;
      end
    end
  end

  assign bus.mem_req_rnw       = rnw_q;
  assign bus.mem_req_addr      = addr_q;
  assign bus.mem_req_tag       = tag_q;
  assign bus.mem_req_data_bits = data_q;
  assign bus.mem_req_data_mask = mask_q;
  assign bus.ic_resp_valid     = ic_resp_valid_q && !reset;
  assign bus.dc_resp_valid     = dc_resp_valid_q && !reset;
  assign bus.ic_resp_data      = resp_data_q;
  assign bus.dc_resp_data      = resp_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter.
// Inputs are driven just after the falling edge and outputs checked 1 time
// unit later, well away from the rising (active) edge.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(28), .DATA_W(128), .TAG_W(4)) bus ();

  mem_arbiter #(.ADDR_W(28), .DATA_W(128), .TAG_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int ic_pulses = 0;
  int dc_pulses = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Count response pulses over the whole run (a stretched pulse counts twice).
  always @(negedge clk) begin
    #2;
    if (bus.ic_resp_valid === 1'b1) ic_pulses++;
    if (bus.dc_resp_valid === 1'b1) dc_pulses++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  // One read transaction: present requests, check grant/command, answer after
  // 'delay' cycles with the expected tag, check the one-cycle response pulse.
  task automatic arb_read(input string name, input bit ic_v, input bit dc_v,
                          input logic [27:0] ic_a, input logic [27:0] dc_a,
                          input bit exp_dc, input int delay, input logic [127:0] rdata);
    logic [3:0] exp_tag;
    exp_tag = exp_dc ? 4'd1 : 4'd0;
    cyc();
    bus.ic_req_valid = ic_v; bus.ic_req_addr = ic_a;
    bus.dc_req_valid = dc_v; bus.dc_req_rnw = 1'b1; bus.dc_req_addr = dc_a;
    bus.mem_req_ready = 1'b1;
    #1;
    check({name, "_ic_ready"}, bus.ic_req_ready, !exp_dc);
    check({name, "_dc_ready"}, bus.dc_req_ready, exp_dc);
    cyc();
    bus.ic_req_valid = 1'b0; bus.dc_req_valid = 1'b0;
    #1;
    check({name, "_cmd_valid"}, bus.mem_req_valid, 1'b1);
    check({name, "_cmd_tag"},   bus.mem_req_tag, exp_tag);
    check({name, "_cmd_addr"},  bus.mem_req_addr, exp_dc ? dc_a : ic_a);
    check({name, "_cmd_rnw"},   bus.mem_req_rnw, 1'b1);
    repeat (delay) cyc();
    bus.mem_resp_valid = 1'b1; bus.mem_resp_tag = exp_tag; bus.mem_resp_data = rdata;
    #1;
    check({name, "_resp_not_early"}, bus.ic_resp_valid | bus.dc_resp_valid, 1'b0);
    cyc();
    bus.mem_resp_valid = 1'b0;
    #1;
    check({name, "_ic_resp_valid"}, bus.ic_resp_valid, !exp_dc);
    check({name, "_dc_resp_valid"}, bus.dc_resp_valid, exp_dc);
    check({name, "_resp_data"}, exp_dc ? bus.dc_resp_data : bus.ic_resp_data, rdata);
    cyc();
    #1;
    check({name, "_pulse_end"}, bus.ic_resp_valid | bus.dc_resp_valid, 1'b0);
  endtask

  localparam logic [127:0] WDATA = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;

  initial begin
    int ic_snap, dc_snap;
    bus.ic_req_valid = 1'b1; bus.ic_req_addr = 28'h0;
    bus.dc_req_valid = 1'b1; bus.dc_req_rnw = 1'b1; bus.dc_req_addr = 28'h0;
    bus.dc_req_data = '0; bus.dc_req_mask = '0;
    bus.mem_req_ready = 1'b1; bus.mem_req_data_ready = 1'b1;
    bus.mem_resp_valid = 1'b0; bus.mem_resp_data = '0; bus.mem_resp_tag = '0;

    // Reset state, with both requests pending to prove ready is held low.
    cyc(); #1;
    check("rst_ic_ready",   bus.ic_req_ready, 1'b0);
    check("rst_dc_ready",   bus.dc_req_ready, 1'b0);
    check("rst_cmd_valid",  bus.mem_req_valid, 1'b0);
    check("rst_data_valid", bus.mem_req_data_valid, 1'b0);
    check("rst_resp_valid", bus.ic_resp_valid | bus.dc_resp_valid, 1'b0);
    check("rst_addr",       bus.mem_req_addr, 28'h0);
    check("rst_tag",        bus.mem_req_tag, 4'h0);
    check("rst_wdata",      bus.mem_req_data_bits, 128'h0);
    cyc();
    reset = 1'b0; bus.ic_req_valid = 1'b0; bus.dc_req_valid = 1'b0;

    // Tie in IDLE, twice.
    arb_read("tie1", 1'b1, 1'b1, 28'h100, 28'h200, 1'b1, 1, 128'h1111);
`ifdef MEM_ARBITER_RR_EN
    arb_read("tie2", 1'b1, 1'b1, 28'h100, 28'h200, 1'b0, 1, 128'h2222);
`else
    arb_read("tie2", 1'b1, 1'b1, 28'h100, 28'h200, 1'b1, 1, 128'h2222);
`endif

    // icache read, response three cycles after the command handshake.
    arb_read("ic_rd", 1'b1, 1'b0, 28'h0000010, 28'h0, 1'b0, 3, 128'hCAFE_F00D_0000_0000_1234_5678_9ABC_DEF0);

    // dcache write: command, then one data beat; no cache response.
    ic_snap = ic_pulses; dc_snap = dc_pulses;
    cyc();
    bus.dc_req_valid = 1'b1; bus.dc_req_rnw = 1'b0; bus.dc_req_addr = 28'h0000020;
    bus.dc_req_data = WDATA; bus.dc_req_mask = 16'hFFFF;
    bus.mem_req_ready = 1'b1; bus.mem_req_data_ready = 1'b0;
    #1;
    check("wr_dc_ready", bus.dc_req_ready, 1'b1);
    cyc();
    bus.dc_req_valid = 1'b0; bus.dc_req_data = '0; bus.dc_req_mask = '0;
    #1;
    check("wr_cmd_valid", bus.mem_req_valid, 1'b1);
    check("wr_cmd_rnw",   bus.mem_req_rnw, 1'b0);
    check("wr_cmd_tag",   bus.mem_req_tag, 4'h1);
    check("wr_cmd_addr",  bus.mem_req_addr, 28'h0000020);
    check("wr_no_early_data", bus.mem_req_data_valid, 1'b0);
    cyc(); #1;
    check("wr_cmd_dropped", bus.mem_req_valid, 1'b0);
    check("wr_data_valid",  bus.mem_req_data_valid, 1'b1);
    check("wr_data_bits",   bus.mem_req_data_bits, WDATA);
    check("wr_data_mask",   bus.mem_req_data_mask, 16'hFFFF);
    cyc();
    bus.mem_req_data_ready = 1'b1;
    #1;
    check("wr_data_hold", bus.mem_req_data_valid, 1'b1);
    cyc();
    bus.dc_req_rnw = 1'b1;
    #1;
    check("wr_data_done", bus.mem_req_data_valid, 1'b0);
    cyc(); cyc(); #3;
    check("wr_no_ic_resp", ic_pulses, ic_snap);
    check("wr_no_dc_resp", dc_pulses, dc_snap);

    // dcache read stalled by memory for 5 cycles, with new requests pending.
    cyc();
    bus.dc_req_valid = 1'b1; bus.dc_req_rnw = 1'b1; bus.dc_req_addr = 28'h3ABCDEF;
    bus.mem_req_ready = 1'b0;
    #1;
    check("stall_dc_ready", bus.dc_req_ready, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      bus.dc_req_addr = 28'h5555555; bus.ic_req_valid = 1'b1; bus.ic_req_addr = 28'h7777777;
      #1;
      check("stall_cmd_valid", bus.mem_req_valid, 1'b1);
      check("stall_addr",      bus.mem_req_addr, 28'h3ABCDEF);
      check("stall_tag",       bus.mem_req_tag, 4'h1);
      check("stall_rnw",       bus.mem_req_rnw, 1'b1);
      check("stall_readies",   bus.ic_req_ready | bus.dc_req_ready, 1'b0);
    end
    cyc();
    bus.dc_req_valid = 1'b0; bus.ic_req_valid = 1'b0; bus.mem_req_ready = 1'b1;
    #1;
    check("stall_release_valid", bus.mem_req_valid, 1'b1);

    // In RESP: foreign tag 7 first, then the real tag 1.
    cyc();
    bus.mem_resp_valid = 1'b1; bus.mem_resp_tag = 4'h7; bus.mem_resp_data = 128'hBAD;
    cyc();
    bus.mem_resp_tag = 4'h1; bus.mem_resp_data = 128'hA5A5_0000_5A5A;
    #1;
    check("tag7_ignored", bus.dc_resp_valid | bus.ic_resp_valid, 1'b0);
    cyc();
    bus.mem_resp_valid = 1'b0;
    #1;
    check("tag1_dc_valid", bus.dc_resp_valid, 1'b1);
    check("tag1_ic_valid", bus.ic_resp_valid, 1'b0);
    check("tag1_dc_data",  bus.dc_resp_data, 128'hA5A5_0000_5A5A);
    cyc(); #1;
    check("tag1_pulse_end", bus.dc_resp_valid, 1'b0);

    // Reset while waiting for a response, then deliver the stale response.
    cyc();
    bus.ic_req_valid = 1'b1; bus.ic_req_addr = 28'h0000040; bus.mem_req_ready = 1'b1;
    #1;
    check("mid_ic_ready", bus.ic_req_ready, 1'b1);
    cyc();
    bus.ic_req_valid = 1'b0;
    #1;
    check("mid_cmd_addr", bus.mem_req_addr, 28'h0000040);
    cyc();
    cyc();
    reset = 1'b1; bus.ic_req_valid = 1'b1;
    cyc(); #1;
    check("mid_rst_ic_ready", bus.ic_req_ready, 1'b0);
    check("mid_rst_addr",     bus.mem_req_addr, 28'h0);
    check("mid_rst_tag",      bus.mem_req_tag, 4'h0);
    ic_snap = ic_pulses;
    cyc();
    reset = 1'b0; bus.ic_req_valid = 1'b0;
    bus.mem_resp_valid = 1'b1; bus.mem_resp_tag = 4'h0; bus.mem_resp_data = 128'hDEAD;
    cyc();
    bus.mem_resp_valid = 1'b0;
    cyc(); cyc(); #3;
    check("late_resp_ignored", ic_pulses, ic_snap);
    arb_read("post_rst", 1'b1, 1'b0, 28'h0000050, 28'h0, 1'b0, 2, 128'h0BAD_CAFE_0000_0001);

    cyc(); cyc(); #3;
`ifdef MEM_ARBITER_RR_EN
    check("total_ic_pulses", ic_pulses, 3);
    check("total_dc_pulses", dc_pulses, 2);
`else
    check("total_ic_pulses", ic_pulses, 2);
    check("total_dc_pulses", dc_pulses, 3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
